// File: rtl/seg_scan_decoder.sv
// Receiver for a multiplexed 6-digit active-low 7-segment bus: debounces each
// scan slot, rebuilds the digit codes and dots, and converts the frame to binary.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  seg_sel,
  input  logic [7:0]  seg_led,
  output logic [23:0] digits,
  output logic [5:0]  points,
  output logic [19:0] value,
  output logic        neg,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        disp_off,
  output logic        sel_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {CAPTURE, CONVERT, DONE} state_t;

  state_t            state, state_next;
  logic [5:0]        sel_q;
  logic [7:0]        led_q;
  logic [13:0]       prev_q;
  logic [3:0]        stab_cnt;
  logic [5:0]        seen;
  logic [5:0][3:0]   code_buf, snap_code;
  logic [5:0]        pt_buf, snap_pt;
  logic [19:0]       acc;
  logic [2:0]        idx;
  logic [TW-1:0]     tcnt;

  logic       same, stable, sel_onehot, sel_idle, accept, tmo_hit;
  logic [5:0] accept_mask;
  logic       snap_en, conv_en, done_en;
  logic       snap_neg, snap_bad;

  function automatic logic [3:0] decode(input logic [6:0] p);
    case (p)
      7'b1000000: decode = 4'd0;
      7'b1111001: decode = 4'd1;
      7'b0100100: decode = 4'd2;
      7'b0110000: decode = 4'd3;
      7'b0011001: decode = 4'd4;
      7'b0010010: decode = 4'd5;
      7'b0000010: decode = 4'd6;
      7'b1111000: decode = 4'd7;
      7'b0000000: decode = 4'd8;
      7'b0010000: decode = 4'd9;
      7'b0111111: decode = 4'd11;
      7'b1111111: decode = 4'd15;
      default:    decode = 4'd14;
    endcase
  endfunction

  function automatic logic [19:0] dv(input logic [3:0] c);
    dv = (c <= 4'd9) ? {16'd0, c} : '0;
  endfunction

  // The event fires on the edge where the count would reach STABLE_CYCLES-1,
  // so the data acted upon is the sample that completed the stable run.
  assign same        = ({sel_q, led_q} == prev_q);
  assign stable      = same && (stab_cnt == 4'(STABLE_CYCLES - 2));
  assign sel_idle    = (sel_q == '1);
  assign sel_onehot  = ($countones(~sel_q) == 1);
  assign accept      = stable && sel_onehot;
  assign accept_mask = accept ? ~sel_q : '0;
  assign tmo_hit     = !accept && (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    snap_neg = 1'b0;
    snap_bad = 1'b0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (snap_code[i] == 4'd11) snap_neg = 1'b1;
      if (snap_code[i] == 4'd14) snap_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= CAPTURE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    snap_en    = 1'b0;
    conv_en    = 1'b0;
    done_en    = 1'b0;
    case (state)
      CAPTURE: if (seen == '1) begin
        snap_en    = 1'b1;
        state_next = CONVERT;
      end
      CONVERT: begin
        conv_en = 1'b1;
        if (idx == 3'd0) state_next = DONE;
      end
      DONE: begin
        done_en    = 1'b1;
        state_next = CAPTURE;
      end
      default: state_next = CAPTURE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= '1;
      led_q       <= '1;
      prev_q      <= '1;
      stab_cnt    <= '0;
      seen        <= '0;
      code_buf    <= '1;
      pt_buf      <= '0;
      snap_code   <= '1;
      snap_pt     <= '0;
      acc         <= '0;
      idx         <= '0;
      tcnt        <= '0;
      digits      <= 24'hFFFFFF;
      points      <= '0;
      value       <= '0;
      neg         <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      disp_off    <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      sel_q  <= seg_sel;
      led_q  <= seg_led;
      prev_q <= {sel_q, led_q};
      if (!same)                 stab_cnt <= '0;
      else if (stab_cnt != '1)   stab_cnt <= stab_cnt + 4'd1;

      sel_err <= stable && !sel_onehot && !sel_idle;

      for (int unsigned i = 0; i < 6; i++) begin
        if (accept_mask[i]) begin
          code_buf[i] <= decode(led_q[6:0]);
          pt_buf[i]   <= ~led_q[7];
        end
      end
      // A digit accepted on the snapshot edge survives into the fresh mask.
      seen <= ((snap_en || tmo_hit) ? 6'b0 : seen) | accept_mask;

      if (accept)                           tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT - 1))    tcnt <= tcnt + 1'b1;
      if (accept)       disp_off <= 1'b0;
      else if (tmo_hit) disp_off <= 1'b1;

      if (snap_en) begin
        snap_code <= code_buf;
        snap_pt   <= pt_buf;
        acc       <= '0;
        idx       <= 3'd5;
      end else if (conv_en) begin
        acc <= (acc << 3) + (acc << 1) + dv(snap_code[idx]);
        idx <= idx - 3'd1;
      end

      frame_valid <= done_en;
      if (done_en) begin
        digits    <= snap_code;
        points    <= snap_pt;
        value     <= acc;
        neg       <= snap_neg;
        frame_err <= snap_bad;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: scans whole frames on the bus and checks
// the decoded outputs, latency, debounce, select errors, timeout and reset abort.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_led;
  logic [23:0] digits;
  logic [5:0]  points;
  logic [19:0] value;
  logic        neg, frame_valid, frame_err, disp_off, sel_err;

  int errors = 0;
  int checks = 0;
  int fv_cnt = 0;
  int se_cnt = 0;
  int fv0, se0;

  seg_scan_decoder #(.STABLE_CYCLES(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .seg_sel(seg_sel), .seg_led(seg_led),
    .digits(digits), .points(points), .value(value), .neg(neg),
    .frame_valid(frame_valid), .frame_err(frame_err),
    .disp_off(disp_off), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_valid) fv_cnt++;
    if (sel_err)     se_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] pat(input int d);
    case (d)
      0:  pat = 7'b1000000;
      1:  pat = 7'b1111001;
      2:  pat = 7'b0100100;
      3:  pat = 7'b0110000;
      4:  pat = 7'b0011001;
      5:  pat = 7'b0010010;
      6:  pat = 7'b0000010;
      7:  pat = 7'b1111000;
      8:  pat = 7'b0000000;
      9:  pat = 7'b0010000;
      11: pat = 7'b0111111;
      14: pat = 7'b0001000;
      default: pat = 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic scan(input int k, input int d, input bit dot, input int hold);
    logic [5:0] one;
    one = 6'b000001;
    seg_sel = ~(one << k);
    seg_led = {~dot, pat(d)};
    repeat (hold) @(negedge clk);
  endtask

  task automatic idle(input int n);
    seg_sel = '1;
    seg_led = '1;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_frame(input logic [23:0] code, input logic [5:0] dots, input int hold);
    for (int k = 5; k >= 0; k--) scan(k, int'(code[k*4 +: 4]), dots[k], hold);
  endtask

  task automatic wait_frame(input string tag, input int budget);
    int start, n;
    start = fv_cnt;
    n = 0;
    while (fv_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_arrived"}, 32'(fv_cnt != start), 32'd1);
  endtask

  task automatic chk_frame(input string tag, input logic [23:0] d, input logic [19:0] v,
                           input logic ng, input logic [5:0] p, input logic fe);
    chk({tag, "_digits"}, d ? digits : digits, d);
    chk({tag, "_value"},  value, v);
    chk({tag, "_neg"},    neg, ng);
    chk({tag, "_points"}, points, p);
    chk({tag, "_ferr"},   frame_err, fe);
  endtask

  initial begin
    rst = 1'b1;
    seg_sel = '1;
    seg_led = '1;
    repeat (2) @(negedge clk);
    chk_frame("reset", 24'hFFFFFF, 20'd0, 1'b0, 6'b0, 1'b0);
    chk("reset_fv", frame_valid, 1'b0);
    chk("reset_doff", disp_off, 1'b0);
    chk("reset_selerr", sel_err, 1'b0);
    rst = 1'b0;

    // "123456": frame_valid exactly 8 edges after the last digit is accepted
    scan_frame(24'h123456, 6'b0, 8);
    seg_sel = '1;
    seg_led = '1;
    repeat (4) @(negedge clk);
    chk("lat_early_fv", frame_valid, 1'b0);
    chk("lat_early_digits", digits, 24'hFFFFFF);
    @(negedge clk);
    chk("lat_fv", frame_valid, 1'b1);
    chk_frame("f123456", 24'h123456, 20'd123456, 1'b0, 6'b0, 1'b0);
    @(negedge clk);
    chk("fv_one_cycle", frame_valid, 1'b0);

    // blank, blank, '-', 0, 4(dot), 2
    scan_frame(24'hFFB042, 6'b000010, 8);
    wait_frame("fneg", 20);
    chk_frame("fneg", 24'hFFB042, 20'd42, 1'b1, 6'b000010, 1'b0);

    // digit0 first shown for only 2 cycles: must not complete the frame
    scan(5, 9, 1'b0, 10);
    scan(4, 8, 1'b0, 10);
    scan(3, 7, 1'b0, 10);
    scan(2, 6, 1'b0, 10);
    scan(1, 5, 1'b0, 10);
    fv0 = fv_cnt;
    scan(0, 3, 1'b0, 2);
    idle(20);
    chk("glitch_no_frame", fv_cnt, fv0);
    scan(0, 0, 1'b0, 10);
    wait_frame("fglitch", 20);
    chk_frame("fglitch", 24'h987650, 20'd987650, 1'b0, 6'b0, 1'b0);

    // non-one-hot select mid-frame, then an unrecognised pattern on digit3
    scan(5, 1, 1'b0, 8);
    scan(4, 2, 1'b0, 8);
    scan(3, 14, 1'b0, 8);
    scan(2, 4, 1'b0, 8);
    scan(1, 5, 1'b0, 8);
    se0 = se_cnt;
    fv0 = fv_cnt;
    seg_sel = 6'b111100;
    seg_led = {1'b1, pat(8)};
    repeat (10) @(negedge clk);
    chk("selerr_once", se_cnt - se0, 1);
    chk("selerr_no_frame", fv_cnt, fv0);
    scan(0, 0, 1'b0, 8);
    wait_frame("ferr", 20);
    chk_frame("ferr", 24'h12E450, 20'd120450, 1'b0, 6'b0, 1'b1);
    chk("ferr_digit3", digits[15:12], 4'hE);

    // timeout: digit5 accepted 5 edges after it is driven, then idle
    scan(5, 0, 1'b0, 8);
    idle(96);
    chk("doff_before", disp_off, 1'b0);
    @(negedge clk);
    chk("doff_at_timeout", disp_off, 1'b1);
    chk_frame("doff_hold", 24'h12E450, 20'd120450, 1'b0, 6'b0, 1'b1);
    idle(40);
    chk("doff_stays", disp_off, 1'b1);
    fv0 = fv_cnt;
    scan(4, 5, 1'b0, 8);
    chk("doff_cleared", disp_off, 1'b0);
    scan(3, 4, 1'b0, 8);
    scan(2, 3, 1'b0, 8);
    scan(1, 2, 1'b0, 8);
    scan(0, 1, 1'b0, 8);
    idle(10);
    chk("timeout_cleared_seen", fv_cnt, fv0);
    scan(5, 0, 1'b0, 8);
    wait_frame("ftmo", 20);
    chk_frame("ftmo", 24'h054321, 20'd54321, 1'b0, 6'b0, 1'b0);

    // reset while converting aborts the frame
    scan_frame(24'h700009, 6'b0, 8);
    fv0 = fv_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_frame("rst_mid", 24'hFFFFFF, 20'd0, 1'b0, 6'b0, 1'b0);
    chk("rst_mid_doff", disp_off, 1'b0);
    idle(15);
    chk("rst_abort_no_frame", fv_cnt, fv0);
    scan_frame(24'h700009, 6'b0, 8);
    wait_frame("frescan", 20);
    chk_frame("frescan", 24'h700009, 20'd700009, 1'b0, 6'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
